// File: rtl/main_function_driver_if.sv
// main_function_driver_if
//   Bundles the three handshake groups around main_function_driver:
//     req_*  : operand request (valid/ready), system front end -> driver
//     fn_*   : enable/finish link, driver <-> main_function
//     rsp_*  : result response (valid/ready), driver -> consumer
//   modport slave  : the driver itself
//   modport master : the environment (front end, main_function, consumer)
interface main_function_driver_if #(
  parameter int CYCLE_WIDTH = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [7:0]             req_a;
  logic [7:0]             req_b;

  logic                   fn_enable;
  logic [7:0]             fn_a;
  logic [7:0]             fn_b;
  logic                   fn_finish;
  logic [23:0]            fn_result;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [23:0]            rsp_result;
  logic [CYCLE_WIDTH-1:0] rsp_cycles;
  logic                   rsp_error;

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready,
    output fn_enable, fn_a, fn_b,
    input  fn_finish, fn_result,
    output rsp_valid, rsp_result, rsp_cycles, rsp_error,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready,
    input  fn_enable, fn_a, fn_b,
    output fn_finish, fn_result,
    input  rsp_valid, rsp_result, rsp_cycles, rsp_error,
    output rsp_ready
  );
endinterface

// File: rtl/main_function_driver.sv
// main_function_driver
//   Initiator for one main_function instance. Accepts an operand pair,
//   fires a one-cycle fn_enable, holds fn_a/fn_b, waits for fn_finish
//   (or a watchdog timeout), then presents result + latency on rsp_*.
// Ports:
//   clock, reset : single clock, asynchronous active-high reset
//   bus          : main_function_driver_if.slave (req_*, fn_*, rsp_*)
// Parameters:
//   CYCLE_WIDTH  : latency counter / rsp_cycles width
//   TIMEOUT      : WAIT edges before abort, 1 <= TIMEOUT < 2**CYCLE_WIDTH
// All outputs are registered. rsp_valid is registered from the HOLD state,
// so it rises one edge after HOLD is entered; response fields are already
// stable by then.
module main_function_driver #(
  parameter int CYCLE_WIDTH = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  main_function_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;

  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_C = CYCLE_WIDTH'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]             fn_a_q, fn_a_d;
  logic [7:0]             fn_b_q, fn_b_d;
  logic                   fn_enable_q, fn_enable_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [23:0]            rsp_result_q, rsp_result_d;
  logic [CYCLE_WIDTH-1:0] rsp_cycles_q, rsp_cycles_d;
  logic                   rsp_error_q, rsp_error_d;

  // Counter never passes TIMEOUT, so this cannot wrap.
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fn_a_d       = fn_a_q;
    fn_b_d       = fn_b_q;
    rsp_result_d = rsp_result_q;
    rsp_cycles_d = rsp_cycles_q;
    rsp_error_d  = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          fn_a_d  = bus.req_a;
          fn_b_d  = bus.req_b;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: state_d = WAIT;  // fn_finish deliberately ignored here
      WAIT: begin
        cnt_d = cnt_inc;
        // Finish has priority over a timeout landing on the same edge.
        if (bus.fn_finish) begin
          rsp_result_d = bus.fn_result;
          rsp_cycles_d = cnt_inc;
          rsp_error_d  = 1'b0;
          state_d      = HOLD;
        end else if (cnt_inc == TIMEOUT_C) begin
          rsp_result_d = '0;
          rsp_cycles_d = TIMEOUT_C;
          rsp_error_d  = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs derived from the next state.
    req_ready_d = (state_d == IDLE);
    fn_enable_d = (state_d == START);
    // Valid only after a full cycle in HOLD; drops on the consuming edge.
    rsp_valid_d = (state_q == HOLD) && (state_d == HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fn_a_q       <= '0;
      fn_b_q       <= '0;
      fn_enable_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cycles_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fn_a_q       <= fn_a_d;
      fn_b_q       <= fn_b_d;
      fn_enable_q  <= fn_enable_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cycles_q <= rsp_cycles_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.fn_enable  = fn_enable_q;
  assign bus.fn_a       = fn_a_q;
  assign bus.fn_b       = fn_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cycles = rsp_cycles_q;
  assign bus.rsp_error  = rsp_error_q;
endmodule
